output_port_scheduler: RTL and testbench
========================================

OUTPUT_PORT_SCHEDULER -- requirements
Module: output_port_scheduler

Interface
REQ-001 Parameter: NUM_REQ, 5, number of input-port requesters.
REQ-002 Parameter: NUM_VC, 4, number of downstream output VCs; the VC id is 2 bits wide.
REQ-003 Parameter: CREDITS, 4, downstream buffer depth per VC and the reset credit value.
REQ-004 Port: clk  input  1  sole clock, rising edge.
REQ-005 Port: rstn  input  1  reset, synchronous and active-low.
REQ-006 Port: req  input  NUM_REQ  per-requester flit request valid.
REQ-007 Port: req_vc  input  2*NUM_REQ  target output VC per requester; requester i uses bits [2i+1:2i].
REQ-008 Port: req_head / req_tail  input  NUM_REQ each  flit is head / tail (both high means a single-flit packet).
REQ-009 Port: credit_in  input  NUM_VC  one credit returned per VC per cycle from downstream.
REQ-010 Port: gnt  output  NUM_REQ  one-hot (or zero) crossbar grant, same cycle as request.
REQ-011 Port: gnt_vc  output  2  VC id of the granted flit; 0 when no grant.
REQ-012 Port: vc_avail  output  NUM_VC  registered output-VC availability flags.
REQ-013 Port: credit_err  output  1  sticky flag, set on credit overflow.

Function
REQ-014 State per VC: credit counter (0..CREDITS), availability flag, owner index (log2 NUM_REQ bits).
REQ-015 Requester i is eligible when req[i]=1, credit[vc]>0, and either (head and vc_avail[vc]=1) or (non-head and vc_avail[vc]=0 and owner[vc]=i).
REQ-016 Grant is combinational: exactly one eligible requester is granted per cycle; gnt is all-zero when none is eligible.
REQ-017 Arbitration is round-robin: the search starts at the index after the last granted requester and wraps NUM_REQ-1 -> 0; the pointer updates only on a grant.
REQ-018 On a grant, credit[gnt_vc] decrements at the next edge.
REQ-019 On credit_in[v], credit[v] increments at the next edge.
REQ-020 A grant and a credit return on the same VC in the same cycle leave credit[v] unchanged.
REQ-021 A credit return at credit[v]=CREDITS without a simultaneous grant leaves the counter at CREDITS and sets credit_err.
REQ-022 A granted head-only flit clears vc_avail[vc] and records owner=i at the next edge.
REQ-023 A granted tail-only flit sets vc_avail[vc] at the next edge.
REQ-024 A granted head+tail flit leaves vc_avail[vc]=1.
REQ-025 Non-eligible requests are held off without error; the requester keeps req asserted until it is granted.
REQ-026 Two requesters heading for the same free VC in one cycle: only the round-robin winner is granted; the loser sees vc_avail=0 next cycle and waits for the tail.

Reset
REQ-027 With rstn=0 at a rising edge: every credit counter=CREDITS, vc_avail=all-ones, owners=0, round-robin pointer=0 (requester 0 has highest priority), credit_err=0.
REQ-028 During reset, gnt=0 and gnt_vc=0 regardless of requests; reset mid-packet abandons all ownership with no further action.

Configuration
REQ-029 Macro OSCHED_CREDIT_LOOKAHEAD_EN, when defined, makes a VC with credit=0 and credit_in[v]=1 in the same cycle eligible; the net counter stays 0 after the grant.
REQ-030 Without OSCHED_CREDIT_LOOKAHEAD_EN, eligibility uses only the registered counter, and a zero-credit VC is granted no earlier than the cycle after the credit returns.

Verification
REQ-031 After reset, req=5'b00001 head+tail on VC2 -> gnt=5'b00001, gnt_vc=2; next cycle credit[2]=3 and vc_avail=4'b1111.
REQ-032 req=5'b10010, both heads on VC1, pointer=0 -> gnt=5'b00010; next cycle vc_avail[1]=0, owner=1, and requester 4 is blocked until requester 1's tail is granted.
REQ-033 Five body flits on VC0 with no credit_in -> four grants, then gnt=0 with credit[0]=0; one credit_in[0] -> grant resumes the next cycle (same cycle with OSCHED_CREDIT_LOOKAHEAD_EN).
REQ-034 All five requesters hold head flits on distinct-credit VCs, with each tail granted immediately -> grants rotate 0,1,2,3,4,0.
REQ-035 credit_in[3]=1 at credit[3]=4 with no grant -> credit[3] stays 4 and credit_err=1 until reset; grant plus credit_in on VC3 in one cycle -> counter unchanged.
REQ-036 rstn=0 for one cycle mid-packet -> all counters=4, vc_avail=4'b1111, and credit_err=0 on the following cycle.

Source files
------------

// File: rtl/output_port_scheduler_if.sv
// Crossbar request/grant bundle between input-port requesters and the output-port scheduler.
interface output_port_scheduler_if #(
  parameter int NUM_REQ = 5,
  parameter int NUM_VC  = 4
);
  localparam int VC_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

  logic [NUM_REQ-1:0]      req;
  logic [VC_W*NUM_REQ-1:0] req_vc;
  logic [NUM_REQ-1:0]      req_head;
  logic [NUM_REQ-1:0]      req_tail;
  logic [NUM_VC-1:0]       credit_in;
  logic [NUM_REQ-1:0]      gnt;
  logic [VC_W-1:0]         gnt_vc;
  logic [NUM_VC-1:0]       vc_avail;
  logic                    credit_err;

  modport master (
    output req, req_vc, req_head, req_tail, credit_in,
    input  gnt, gnt_vc, vc_avail, credit_err
  );

  modport slave (
    input  req, req_vc, req_head, req_tail, credit_in,
    output gnt, gnt_vc, vc_avail, credit_err
  );
endinterface

// File: rtl/output_port_scheduler.sv
// Output-port scheduler: per-VC credit/ownership tracking plus round-robin crossbar grant.
// Optional macro OSCHED_CREDIT_LOOKAHEAD_EN lets a same-cycle credit return satisfy a zero-credit VC.

module osched_vc #(
  parameter int CREDITS = 4,
  parameter int IDX_W   = 3,
  parameter int CW      = $clog2(CREDITS + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             take,
  input  logic             take_head,
  input  logic             take_tail,
  input  logic [IDX_W-1:0] take_idx,
  input  logic             ret,
  output logic [CW-1:0]    credit_q,
  output logic             avail_q,
  output logic [IDX_W-1:0] owner_q,
  output logic             ovf
);
  logic [CW-1:0]    credit_d;
  logic             avail_d;
  logic [IDX_W-1:0] owner_d;

  always_comb begin
    credit_d = credit_q;
    avail_d  = avail_q;
    owner_d  = owner_q;
    ovf      = 1'b0;
    if (take && !ret) begin
      credit_d = credit_q - CW'(1);
    end else if (ret && !take) begin
      // A return into a full buffer is dropped and flagged.
      if (credit_q == CW'(CREDITS)) ovf = 1'b1;
      else                          credit_d = credit_q + CW'(1);
    end
    if (take && take_head && !take_tail) begin
      avail_d = 1'b0;
      owner_d = take_idx;
    end else if (take && take_tail && !take_head) begin
      avail_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      credit_q <= CW'(CREDITS);
      avail_q  <= 1'b1;
      owner_q  <= '0;
    end else begin
      credit_q <= credit_d;
      avail_q  <= avail_d;
      owner_q  <= owner_d;
    end
  end
endmodule

module output_port_scheduler #(
  parameter int NUM_REQ = 5,
  parameter int NUM_VC  = 4,
  parameter int CREDITS = 4
) (
  input logic                   clk,
  input logic                   rstn,
  output_port_scheduler_if.slave bus
);
  localparam int VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW    = $clog2(CREDITS + 1);

  logic [NUM_REQ-1:0][VC_W-1:0] rvc;
  logic [NUM_VC-1:0][CW-1:0]    credit_q;
  logic [NUM_VC-1:0][IDX_W-1:0] owner_q;
  logic [NUM_VC-1:0]            avail_q, has_credit, vc_take, ovf;
  logic [NUM_REQ-1:0]           elig, gnt;
  logic [IDX_W-1:0]             ptr_q, ptr_d, win;
  logic [VC_W-1:0]              gnt_vc;
  logic                         found, credit_err_q, credit_err_d;
  int                           rr_idx;

  assign rvc = bus.req_vc;

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
`ifdef OSCHED_CREDIT_LOOKAHEAD_EN
      has_credit[v] = (credit_q[v] != '0) || bus.credit_in[v];
`else
      has_credit[v] = (credit_q[v] != '0);
`endif
    end
  end

  // Heads need a free VC; body/tail flits may only follow on the VC their packet owns.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = rstn && bus.req[i] && has_credit[rvc[i]] &&
                (bus.req_head[i] ? avail_q[rvc[i]]
                                 : (!avail_q[rvc[i]] && owner_q[rvc[i]] == IDX_W'(i)));
    end
  end

  always_comb begin
    found  = 1'b0;
    win    = '0;
    rr_idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_idx = int'(ptr_q) + k;
      if (rr_idx >= NUM_REQ) rr_idx = rr_idx - NUM_REQ;
      if (!found && elig[rr_idx]) begin
        found = 1'b1;
        win   = IDX_W'(rr_idx);
      end
    end
    gnt     = '0;
    gnt_vc  = '0;
    vc_take = '0;
    ptr_d   = ptr_q;
    if (found) begin
      gnt[win]        = 1'b1;
      gnt_vc          = rvc[win];
      vc_take[gnt_vc] = 1'b1;
      ptr_d           = (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + IDX_W'(1);
    end
  end

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    osched_vc #(.CREDITS(CREDITS), .IDX_W(IDX_W), .CW(CW)) u_vc (
      .clk       (clk),
      .rstn      (rstn),
      .take      (vc_take[v]),
      .take_head (bus.req_head[win]),
      .take_tail (bus.req_tail[win]),
      .take_idx  (win),
      .ret       (bus.credit_in[v]),
      .credit_q  (credit_q[v]),
      .avail_q   (avail_q[v]),
      .owner_q   (owner_q[v]),
      .ovf       (ovf[v])
    );
  end

  assign credit_err_d = credit_err_q | (|ovf);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr_q        <= '0;
      credit_err_q <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign bus.gnt        = gnt;
  assign bus.gnt_vc     = gnt_vc;
  assign bus.vc_avail   = avail_q;
  assign bus.credit_err = credit_err_q;
endmodule

// File: tb/tb_output_port_scheduler.sv
// Directed bench for output_port_scheduler: reset, VC ownership, credits, overflow, round-robin.
module tb_output_port_scheduler;
  logic clk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   errors = 0;

  output_port_scheduler_if #(.NUM_REQ(5), .NUM_VC(4)) bus ();

  output_port_scheduler #(.NUM_REQ(5), .NUM_VC(4), .CREDITS(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] r, input logic [4:0] h, input logic [4:0] t,
                       input logic [9:0] vcs, input logic [3:0] ci);
    bus.req       = r;
    bus.req_head  = h;
    bus.req_tail  = t;
    bus.req_vc    = vcs;
    bus.credit_in = ci;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // A: reset with every requester asking
    rstn = 1'b0;
    drive(5'b11111, 5'b11111, 5'b11111, 10'd0, 4'b0000);
    @(negedge clk);
    chk("rst_gnt", bus.gnt, 5'b00000);
    chk("rst_gnt_vc", bus.gnt_vc, 2'd0);
    chk("rst_avail", bus.vc_avail, 4'b1111);
    chk("rst_err", bus.credit_err, 1'b0);
    cyc();
    rstn = 1'b1;

    // B: single-flit packet from requester 0 on VC2
    drive(5'b00001, 5'b00001, 5'b00001, {2'd0, 2'd0, 2'd0, 2'd0, 2'd2}, 4'b0000);
    @(negedge clk);
    chk("b_gnt", bus.gnt, 5'b00001);
    chk("b_gnt_vc", bus.gnt_vc, 2'd2);
    cyc();
    drive(5'b00000, 5'b00000, 5'b00000, 10'd0, 4'b0000);
    @(negedge clk);
    chk("b_avail", bus.vc_avail, 4'b1111);
    chk("b_idle_gnt", bus.gnt, 5'b00000);
    cyc();

    // C: requesters 1 and 4 race for VC1
    drive(5'b10010, 5'b10010, 5'b00000, {2'd1, 2'd0, 2'd0, 2'd1, 2'd0}, 4'b0000);
    @(negedge clk);
    chk("c_race_gnt", bus.gnt, 5'b00010);
    chk("c_race_vc", bus.gnt_vc, 2'd1);
    cyc();
    drive(5'b10010, 5'b10000, 5'b00000, {2'd1, 2'd0, 2'd0, 2'd1, 2'd0}, 4'b0000);
    @(negedge clk);
    chk("c_avail_owned", bus.vc_avail, 4'b1101);
    chk("c_body_gnt", bus.gnt, 5'b00010);
    cyc();
    drive(5'b10010, 5'b10000, 5'b00010, {2'd1, 2'd0, 2'd0, 2'd1, 2'd0}, 4'b0000);
    @(negedge clk);
    chk("c_tail_gnt", bus.gnt, 5'b00010);
    cyc();
    drive(5'b10000, 5'b10000, 5'b10000, {2'd1, 2'd0, 2'd0, 2'd1, 2'd0}, 4'b0000);
    @(negedge clk);
    chk("c_avail_freed", bus.vc_avail, 4'b1111);
    chk("c_r4_gnt", bus.gnt, 5'b10000);
    cyc();
    @(negedge clk);
    chk("c_vc1_empty", bus.gnt, 5'b00000);
    cyc();

    // D: requester 0 packet on VC0 runs out of credit
    drive(5'b00001, 5'b00001, 5'b00000, 10'd0, 4'b0000);
    @(negedge clk);
    chk("d_head_gnt", bus.gnt, 5'b00001);
    cyc();
    drive(5'b00001, 5'b00000, 5'b00000, 10'd0, 4'b0000);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("d_body_gnt", bus.gnt, 5'b00001);
      cyc();
    end
    @(negedge clk);
    chk("d_dry_gnt", bus.gnt, 5'b00000);
    chk("d_dry_vc", bus.gnt_vc, 2'd0);
    chk("d_dry_avail", bus.vc_avail, 4'b1110);
    cyc();
    drive(5'b00001, 5'b00000, 5'b00000, 10'd0, 4'b0001);
    @(negedge clk);
`ifdef OSCHED_CREDIT_LOOKAHEAD_EN
    chk("d_ret_gnt", bus.gnt, 5'b00001);
`else
    chk("d_ret_gnt", bus.gnt, 5'b00000);
`endif
    cyc();
    drive(5'b00001, 5'b00000, 5'b00000, 10'd0, 4'b0000);
    @(negedge clk);
`ifdef OSCHED_CREDIT_LOOKAHEAD_EN
    chk("d_after_gnt", bus.gnt, 5'b00000);
`else
    chk("d_after_gnt", bus.gnt, 5'b00001);
`endif
    cyc();

    // E: overflow on full VC3, then grant+return on VC3 keeps the count at 4
    drive(5'b00000, 5'b00000, 5'b00000, 10'd0, 4'b1000);
    @(negedge clk);
    chk("e_err_before", bus.credit_err, 1'b0);
    cyc();
    drive(5'b00000, 5'b00000, 5'b00000, 10'd0, 4'b0000);
    @(negedge clk);
    chk("e_err_set", bus.credit_err, 1'b1);
    cyc();
    drive(5'b00100, 5'b00100, 5'b00100, {2'd0, 2'd0, 2'd3, 2'd0, 2'd0}, 4'b1000);
    @(negedge clk);
    chk("e_both_gnt", bus.gnt, 5'b00100);
    chk("e_both_vc", bus.gnt_vc, 2'd3);
    cyc();
    drive(5'b00100, 5'b00100, 5'b00100, {2'd0, 2'd0, 2'd3, 2'd0, 2'd0}, 4'b0000);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("e_vc3_gnt", bus.gnt, 5'b00100);
      cyc();
    end
    @(negedge clk);
    chk("e_vc3_dry", bus.gnt, 5'b00000);
    chk("e_err_sticky", bus.credit_err, 1'b1);
    cyc();

    // F: one-cycle reset while VC0 is still owned
    rstn = 1'b0;
    drive(5'b00100, 5'b00100, 5'b00100, {2'd0, 2'd0, 2'd2, 2'd0, 2'd0}, 4'b0000);
    @(negedge clk);
    chk("f_rst_gnt", bus.gnt, 5'b00000);
    cyc();
    rstn = 1'b1;
    drive(5'b00000, 5'b00000, 5'b00000, 10'd0, 4'b0000);
    @(negedge clk);
    chk("f_avail", bus.vc_avail, 4'b1111);
    chk("f_err", bus.credit_err, 1'b0);
    cyc();

    // G: all five single-flit requesters rotate 0,1,2,3,4,0
    drive(5'b11111, 5'b11111, 5'b11111, {2'd0, 2'd3, 2'd2, 2'd1, 2'd0}, 4'b0000);
    @(negedge clk); chk("g_rr0", bus.gnt, 5'b00001); chk("g_vc0", bus.gnt_vc, 2'd0); cyc();
    @(negedge clk); chk("g_rr1", bus.gnt, 5'b00010); chk("g_vc1", bus.gnt_vc, 2'd1); cyc();
    @(negedge clk); chk("g_rr2", bus.gnt, 5'b00100); chk("g_vc2", bus.gnt_vc, 2'd2); cyc();
    @(negedge clk); chk("g_rr3", bus.gnt, 5'b01000); chk("g_vc3", bus.gnt_vc, 2'd3); cyc();
    @(negedge clk); chk("g_rr4", bus.gnt, 5'b10000); chk("g_vc4", bus.gnt_vc, 2'd0); cyc();
    @(negedge clk); chk("g_rr5", bus.gnt, 5'b00001); chk("g_vc5", bus.gnt_vc, 2'd0); cyc();

    // VC3 was refilled to 4 by reset and has spent one: three more grants
    drive(5'b01000, 5'b01000, 5'b01000, {2'd0, 2'd3, 2'd2, 2'd1, 2'd0}, 4'b0000);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("g_vc3_gnt", bus.gnt, 5'b01000);
      cyc();
    end
    @(negedge clk);
    chk("g_vc3_dry", bus.gnt, 5'b00000);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
